ring_rr_arbiter: RTL and testbench
==================================

# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters. Priority is held in a one-hot rotating ring pointer. The block sits between the requesting engines and the shared datapath and issues a single one-hot grant that is held until the owner releases it. The pointer advances one position past each released owner, so every requester is served within N grant tenures.

## Interface
Parameters:
- N, 4: number of requesters; N ≥ 2.
- HOLD_MAX, 16: maximum grant tenure in cycles. Used only when GRANT_TIMEOUT_EN is defined. HOLD_MAX ≥ 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request per requester; held high for as long as access is wanted.
- gnt  output  N  registered one-hot grant, or all zeros.
- busy  output  1  registered; high while any gnt bit is high.
- ptr  output  N  registered one-hot priority pointer; the set bit has highest priority.
- timeout  output  1  registered one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values: gnt=0, busy=0, ptr=1 (bit 0 set), timeout=0, state=IDLE, hold counter=0.
- State IDLE:
  - If req≠0 at an edge, the winner is the first set req bit found by scanning upward from ptr's bit index, inclusive, wrapping from N-1 to 0.
  - At that edge: gnt←winner one-hot, busy←1, state←GRANT.
  - If req=0, stay in IDLE. ptr never moves in IDLE.
- State GRANT, normal release:
  - If req[owner]=0 at an edge: gnt←0, busy←0, ptr←owner rotated left by 1 (bit N-1 wraps to bit 0), state←IDLE.
  - Requests from other requesters are ignored during GRANT; there is no preemption.
- State GRANT, hold: if req[owner]=1, keep gnt unchanged.
- Owner drops req while another requester raises req in the same cycle: release first. The new request is arbitrated in IDLE on the next edge against the rotated ptr.
- gnt is one-hot or zero at all times. Only bits with req set at the arbitration edge can be granted.
- Reset mid-grant: all state returns to reset values immediately, with no pulse on timeout.

## Timing
- Grant latency: req sampled high at edge k gives gnt high after edge k (one cycle) when the arbiter is IDLE.
- Release latency: req[owner] sampled low at edge k clears gnt after edge k.
- Minimum gap: one IDLE cycle with gnt=0 between consecutive grants. Back-to-back throughput is one grant per tenure+1 cycles.
- Worst-case wait for a requester holding req continuously: N-1 tenures plus N-1 idle cycles.

## Configuration
- GRANT_TIMEOUT_EN defined:
  - A hold counter of width $clog2(HOLD_MAX+1) clears on entry to GRANT and increments each GRANT cycle.
  - At the edge where the counter equals HOLD_MAX-1 and req[owner]=1: gnt←0, busy←0, ptr←owner rotated left, state←IDLE, timeout←1 for exactly one cycle. Tenure is therefore exactly HOLD_MAX cycles.
  - If the owner drops req on that same edge, it is a normal release and timeout stays 0.
  - A requester still holding req after a timeout re-arbitrates normally, at the lowest priority.
- GRANT_TIMEOUT_EN undefined: no counter is built, timeout is tied to 0, and a tenure is unbounded.

## Structure
- Package ring_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - the default N and HOLD_MAX localparams;
  - a rotate-left-by-one function for N-bit one-hot vectors.
- Sub-module ring_pointer holds the N-bit one-hot register.
  - It resets to 1 and rotates left by one on an advance strobe, with load-from-owner semantics (ptr←rotl(owner)).
  - The arbiter core holds the FSM, the priority scan and the optional timeout counter.

## Test plan
- Reset: with rst=1 and req=4'b1111, hold gnt=0, busy=0, ptr=4'b0001 and timeout=0 for every cycle. After deassertion, gnt=4'b0001 one edge later.
- Rotation: hold req=4'b1111 and drop each owner's req for one cycle after a 3-cycle tenure. Grant order is 0001, 0010, 0100, 1000, 0001, with one idle cycle between grants.
- Wrap and skip: ptr=4'b0100 with req=4'b0011 gives gnt=4'b0001. Release it, then ptr=4'b0010 and the next grant is 4'b0010.
- Simultaneous: the owner at bit 1 drops req while req[3] rises in the same cycle. One cycle later gnt=0 and ptr=4'b0100; the cycle after that, gnt=4'b1000.
- Timeout (GRANT_TIMEOUT_EN, HOLD_MAX=16): req=4'b0001 held high forever. gnt=4'b0001 for exactly 16 cycles, then timeout pulses high for one cycle and gnt=0. The grant is then reissued after one idle cycle. With the macro undefined, the grant persists and timeout stays 0.
- Reset mid-grant: assert rst asynchronously during a grant at bit 2. gnt, busy and ptr take their reset values before the next clock edge.

Source files
------------

// File: rtl/ring_arb_pkg.sv
// rtl/ring_arb_pkg.sv - shared types, defaults and ring rotate helper for ring_rr_arbiter
package ring_arb_pkg;

    localparam int RING_N_DEF        = 4;
    localparam int RING_HOLD_MAX_DEF = 16;

    // Widest ring the rotate helper supports; callers size-cast in and out.
    localparam int RING_MAX_N = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [RING_MAX_N-1:0] ring_rotl1(
        input logic [RING_MAX_N-1:0] v,
        input int                    n
    );
        logic [RING_MAX_N-1:0] mask;
        mask = {RING_MAX_N{1'b1}} >> (RING_MAX_N - n);
        return ((v << 1) | (v >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_pointer.sv
// rtl/ring_pointer.sv - one-hot priority pointer, loads the owner rotated left by one on advance
module ring_pointer
    import ring_arb_pkg::*;
#(
    parameter int N = RING_N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic [N-1:0] owner,
    output logic [N-1:0] ptr
);

    logic [N-1:0] next_ptr;

    assign next_ptr = N'(ring_rotl1(RING_MAX_N'(owner), N));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= N'(1);
        end else if (advance) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with held grants; GRANT_TIMEOUT_EN adds forced revocation
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = RING_N_DEF,
    parameter int HOLD_MAX = RING_HOLD_MAX_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         busy,
    output logic [N-1:0] ptr,
    output logic         timeout
);

    if (N < 2 || HOLD_MAX < 2) begin : g_bad_params
        $error("ring_rr_arbiter: N and HOLD_MAX must both be at least 2");
    end

    state_t       state;
    logic [N-1:0] upper;
    logic [N-1:0] winner;
    logic         owner_req;
    logic         expire;
    logic         advance;

    // Lowest set request at or above the pointer, else wrap to the lowest set request overall.
    assign upper     = req & ~(ptr - N'(1));
    assign winner    = (|upper) ? (upper & (~upper + N'(1))) : (req & (~req + N'(1)));
    assign owner_req = |(req & gnt);

`ifdef GRANT_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    logic [CNT_W-1:0] hold_cnt;

    // An owner dropping req on the last allowed cycle is a plain release, not a timeout.
    assign expire = owner_req && (hold_cnt == CNT_W'(HOLD_MAX - 1));
`else
    assign expire = 1'b0;
`endif

    assign advance = (state == GRANT) && (!owner_req || expire);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            hold_cnt <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= winner;
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef GRANT_TIMEOUT_EN
                        hold_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (advance) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                        timeout <= expire;
                    end
`ifdef GRANT_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    ring_pointer #(
        .N(N)
    ) u_ring_pointer (
        .clk    (clk),
        .rst    (rst),
        .advance(advance),
        .owner  (gnt),
        .ptr    (ptr)
    );

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// tb/tb_ring_rr_arbiter.sv - vector table, corner sequences and random run against a reference model
module tb_ring_rr_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 16;
`ifdef GRANT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic         busy;
    logic [N-1:0] ptr;
    logic         timeout;

    int total = 0;
    int bad   = 0;

    ring_rr_arbiter #(.N(N), .HOLD_MAX(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .busy   (busy),
        .ptr    (ptr),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] ptr;
        logic       busy;
    } vec_t;

    vec_t tbl[26];

    // Reference: owner index (-1 when free), priority index, cycles the owner has held the grant.
    int m_owner;
    int m_prio;
    int m_tenure;
    bit m_to;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_prio   = 0;
        m_tenure = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (r != 4'b0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && r[(m_prio + k) % N]) m_owner = (m_prio + k) % N;
                end
                m_tenure = 1;
            end
        end else if (!r[m_owner]) begin
            m_prio  = (m_owner + 1) % N;
            m_owner = -1;
        end else if (TO_EN && m_tenure == HOLD) begin
            m_prio  = (m_owner + 1) % N;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_tenure++;
        end
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit to_seen;
        logic [3:0] r;
        logic [3:0] flip;

        tbl[0]  = '{4'b1111, 4'b0001, 4'b0001, 1'b1};
        tbl[1]  = '{4'b1111, 4'b0001, 4'b0001, 1'b1};
        tbl[2]  = '{4'b1111, 4'b0001, 4'b0001, 1'b1};
        tbl[3]  = '{4'b1110, 4'b0000, 4'b0010, 1'b0};
        tbl[4]  = '{4'b1111, 4'b0010, 4'b0010, 1'b1};
        tbl[5]  = '{4'b1111, 4'b0010, 4'b0010, 1'b1};
        tbl[6]  = '{4'b1111, 4'b0010, 4'b0010, 1'b1};
        tbl[7]  = '{4'b1101, 4'b0000, 4'b0100, 1'b0};
        tbl[8]  = '{4'b1111, 4'b0100, 4'b0100, 1'b1};
        tbl[9]  = '{4'b1111, 4'b0100, 4'b0100, 1'b1};
        tbl[10] = '{4'b1111, 4'b0100, 4'b0100, 1'b1};
        tbl[11] = '{4'b1011, 4'b0000, 4'b1000, 1'b0};
        tbl[12] = '{4'b1111, 4'b1000, 4'b1000, 1'b1};
        tbl[13] = '{4'b1111, 4'b1000, 4'b1000, 1'b1};
        tbl[14] = '{4'b1111, 4'b1000, 4'b1000, 1'b1};
        tbl[15] = '{4'b0111, 4'b0000, 4'b0001, 1'b0};
        tbl[16] = '{4'b1111, 4'b0001, 4'b0001, 1'b1};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0010, 1'b0};
        tbl[18] = '{4'b0010, 4'b0010, 4'b0010, 1'b1};
        tbl[19] = '{4'b0000, 4'b0000, 4'b0100, 1'b0};
        tbl[20] = '{4'b0011, 4'b0001, 4'b0100, 1'b1};
        tbl[21] = '{4'b0010, 4'b0000, 4'b0010, 1'b0};
        tbl[22] = '{4'b0010, 4'b0010, 4'b0010, 1'b1};
        tbl[23] = '{4'b1000, 4'b0000, 4'b0100, 1'b0};
        tbl[24] = '{4'b1000, 4'b1000, 4'b0100, 1'b1};
        tbl[25] = '{4'b0000, 4'b0000, 4'b0001, 1'b0};

        // Reset held with all requests active.
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_ptr", 32'(ptr), 32'h1);
            chk("rst_timeout", 32'(timeout), 32'h0);
        end
        rst = 1'b0;
        tick();
        chk("first_gnt", 32'(gnt), 32'h1);

        do_reset();
        for (int i = 0; i < 26; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_ptr", i), 32'(ptr), 32'(tbl[i].ptr));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'h0);
        end

        // Asynchronous reset in the middle of a grant at bit 2.
        req = 4'b0100;
        tick();
        chk("mid_gnt_before", 32'(gnt), 32'h4);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ptr", 32'(ptr), 32'h1);
        chk("mid_rst_timeout", 32'(timeout), 32'h0);
        tick();
        rst = 1'b0;
        req = '0;

        // Single requester holding forever.
        do_reset();
        req = 4'b0001;
        n = 0;
        to_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            to_seen |= timeout;
            if (gnt == 4'b0001) n++;
            else break;
        end
        chk("hold_tenure", 32'(n), TO_EN ? 32'd16 : 32'd40);
`ifdef GRANT_TIMEOUT_EN
        chk("to_pulse", 32'(timeout), 32'h1);
        chk("to_gnt_cleared", 32'(gnt), 32'h0);
        chk("to_ptr", 32'(ptr), 32'h2);
        tick();
        chk("to_pulse_end", 32'(timeout), 32'h0);
        chk("to_regrant", 32'(gnt), 32'h1);
`else
        chk("no_to_seen", 32'(to_seen), 32'h0);
        chk("no_to_busy", 32'(busy), 32'h1);
`endif

        // Random traffic against the reference model.
        do_reset();
        r = '0;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++) flip[b] = ($urandom_range(0, 7) == 0);
            r = r ^ flip;
            req = r;
            model_step(r);
            tick();
            chk("rnd_gnt", 32'(gnt), (m_owner < 0) ? 32'h0 : (32'h1 << m_owner));
            chk("rnd_ptr", 32'(ptr), 32'h1 << m_prio);
            chk("rnd_busy", 32'(busy), (m_owner < 0) ? 32'h0 : 32'h1);
            chk("rnd_timeout", 32'(timeout), 32'(m_to));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
